// File: rtl/fifo_rd_packer_pkg.sv
// Shared definitions for the FIFO read-side packer.
//
// Contents:
//   FIFO_WIDTH_DEF / FIFO_DEPTH_DEF / PACK_RATIO_DEF - default sizes of the FIFO
//                                                      and of the packer
//   pk_state_e - packer control state (FILL: reading and packing,
//                FLUSH: draining a partial beat)
//   keep_bit   - keep-mask helper: a slot is valid when its index is below
//                the number of captured words
package fifo_rd_packer_pkg;

  localparam int FIFO_WIDTH_DEF = 16;
  localparam int FIFO_DEPTH_DEF = 8;
  localparam int PACK_RATIO_DEF = 2;

  typedef enum logic [0:0] {
    FILL  = 1'b0,
    FLUSH = 1'b1
  } pk_state_e;

  // One bit of the keep mask (1 << cnt) - 1, evaluated per slot so callers
  // of any PACK_RATIO can build their mask without width juggling.
  function automatic logic keep_bit(input int unsigned slot, input int unsigned cnt);
    return slot < cnt;
  endfunction

endpackage

// File: rtl/fifo_rd_packer_if.sv
// Packed-beat stream between the packer and its sink.
//
// Signals:
//   m_data  - packed beat, slot k occupies bits [k*W +: W]
//   m_keep  - one valid bit per slot
//   m_valid - beat valid (driven by the packer)
//   m_ready - sink accepts the beat (driven by the sink)
// Modports:
//   master - packer side
//   slave  - sink side
interface fifo_rd_packer_if #(
  parameter int DATA_W = 32,
  parameter int KEEP_W = 2
);

  logic [DATA_W-1:0] m_data;
  logic [KEEP_W-1:0] m_keep;
  logic              m_valid;
  logic              m_ready;

  modport master (
    output m_data,
    output m_keep,
    output m_valid,
    input  m_ready
  );

  modport slave (
    input  m_data,
    input  m_keep,
    input  m_valid,
    output m_ready
  );

endinterface

// File: rtl/fifo_rd_packer_out_reg.sv
// Output holding register of the packer (module fifo_pack_out_reg).
// Holds one packed beat on a valid/ready port; the beat stays stable until
// the sink accepts it.
//
// Ports:
//   clk       in  system clock, rising edge
//   rst_n     in  asynchronous active-low reset
//   load      in  capture load_data/load_keep and raise m_valid
//   load_data in  beat to present
//   load_keep in  slot-valid mask to present
//   free      out register can take a new beat this cycle
//   beat      master modport of fifo_rd_packer_if
module fifo_pack_out_reg #(
  parameter int DATA_W = 32,
  parameter int KEEP_W = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [DATA_W-1:0] load_data,
  input  logic [KEEP_W-1:0] load_keep,
  output logic              free,
  fifo_rd_packer_if.master  beat
);

  // Free when empty, or when the current beat leaves this very cycle, so a
  // new beat can follow back-to-back without a bubble.
  assign free = !beat.m_valid || beat.m_ready;

  // Beat register: load wins over accept, since a load is only issued when
  // the register is free.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat.m_valid <= 1'b0;
      beat.m_data  <= '0;
      beat.m_keep  <= '0;
    end else if (load) begin
      beat.m_valid <= 1'b1;
      beat.m_data  <= load_data;
      beat.m_keep  <= load_keep;
    end else if (beat.m_ready) begin
      beat.m_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/fifo_rd_packer.sv
// Downstream drain stage of the FIFO: reads words with one-cycle read
// latency, packs PACK_RATIO words into one wide beat (first word in the
// LSB slot) and presents it on a valid/ready stream. A flush pulse emits
// whatever has been captured as a partial beat with a per-word keep mask.
//
// Ports:
//   clk            in  system clock, rising edge
//   rst_n          in  asynchronous active-low reset (shared with the FIFO)
//   fifo_data_out  in  FIFO read data, valid the cycle after rd_en && !empty
//   fifo_empty     in  FIFO empty flag
//   fifo_underflow in  FIFO underflow flag
//   fifo_rd_en     out FIFO read enable
//   beat           master modport of fifo_rd_packer_if (m_data/m_keep/m_valid/m_ready)
//   flush          in  one-cycle pulse: drain a partial beat
//   flush_done     out one-cycle pulse: flush finished
//   err_underflow  out sticky: FIFO underflow seen since reset
//
// Optional feature, macro FIFO_RD_PACKER_STATS_EN:
//   stat_beats   out [31:0] accepted beats (wraps)
//   stat_partial out [15:0] accepted partial beats (wraps)
module fifo_rd_packer
  import fifo_rd_packer_pkg::*;
#(
  parameter int FIFO_WIDTH = FIFO_WIDTH_DEF,
  parameter int PACK_RATIO = PACK_RATIO_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [FIFO_WIDTH-1:0] fifo_data_out,
  input  logic                  fifo_empty,
  input  logic                  fifo_underflow,
  output logic                  fifo_rd_en,
  fifo_rd_packer_if.master      beat,
  input  logic                  flush,
  output logic                  flush_done,
  output logic                  err_underflow
`ifdef FIFO_RD_PACKER_STATS_EN
  ,
  output logic [31:0]           stat_beats,
  output logic [15:0]           stat_partial
`endif
);

  localparam int CW = $clog2(PACK_RATIO + 1);
  localparam logic [CW-1:0] RATIO_CNT = CW'(PACK_RATIO);
  localparam logic [CW:0]   RATIO_EXT = (CW + 1)'(PACK_RATIO);

  pk_state_e state;
  pk_state_e state_next;

  logic [CW-1:0]                    wcnt;
  logic                             rd_pend;
  logic [FIFO_WIDTH-1:0]            acc [PACK_RATIO];
  logic [CW:0]                      fill_lvl;
  logic                             acc_full;
  logic                             out_free;
  logic                             load;
  logic [FIFO_WIDTH*PACK_RATIO-1:0] load_data;
  logic [PACK_RATIO-1:0]            load_keep;

  // Words already captured plus the one still in flight; reads stop once
  // that covers every slot, so landing data never has to be refused.
  assign fill_lvl = {1'b0, wcnt} + {{CW{1'b0}}, rd_pend};
  assign acc_full = (wcnt == RATIO_CNT);

  // rst_n gates the read so no read is requested while reset is held;
  // flush blocks reads in the same cycle it arrives.
  assign fifo_rd_en = rst_n && (state == FILL) && !flush && !fifo_empty &&
                      (fill_lvl < RATIO_EXT);

  // Control FSM: FILL transfers full beats; FLUSH waits for the in-flight
  // read to land, then sends what is there (or nothing) and signals done.
  always_comb begin
    state_next = state;
    load       = 1'b0;
    flush_done = 1'b0;
    case (state)
      FILL: begin
        if (acc_full && out_free) begin
          load = 1'b1;
        end
        if (flush) begin
          state_next = FLUSH;
        end
      end
      FLUSH: begin
        if (!rd_pend) begin
          if (wcnt != '0) begin
            if (out_free) begin
              load       = 1'b1;
              flush_done = 1'b1;
              state_next = FILL;
            end
          end else begin
            flush_done = 1'b1;
            state_next = FILL;
          end
        end
      end
      default: state_next = FILL;
    endcase
  end

  // Beat assembly: slots at or above wcnt are zeroed so a partial beat
  // never exposes stale words from an earlier beat.
  always_comb begin
    load_data = '0;
    load_keep = '0;
    for (int k = 0; k < PACK_RATIO; k++) begin
      load_keep[k] = keep_bit(k, 32'(wcnt));
      load_data[k*FIFO_WIDTH +: FIFO_WIDTH] = load_keep[k] ? acc[k] : '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= FILL;
    end else begin
      state <= state_next;
    end
  end

  // Read-latency tracker: a word arrives the cycle after an accepted read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_pend <= 1'b0;
    end else begin
      rd_pend <= fifo_rd_en && !fifo_empty;
    end
  end

  // Slot counter: a transfer and a landing never share a cycle, because
  // a full accumulator implies no read is in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wcnt <= '0;
    end else if (load) begin
      wcnt <= '0;
    end else if (rd_pend) begin
      wcnt <= wcnt + CW'(1);
    end
  end

  // Accumulator: landing word goes into slot wcnt.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < PACK_RATIO; k++) begin
        acc[k] <= '0;
      end
    end else begin
      for (int k = 0; k < PACK_RATIO; k++) begin
        if (rd_pend && (wcnt == CW'(k))) begin
          acc[k] <= fifo_data_out;
        end
      end
    end
  end

  // Sticky underflow flag, cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_underflow <= 1'b0;
    end else if (fifo_underflow) begin
      err_underflow <= 1'b1;
    end
  end

  fifo_pack_out_reg #(
    .DATA_W (FIFO_WIDTH * PACK_RATIO),
    .KEEP_W (PACK_RATIO)
  ) u_out_reg (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (load),
    .load_data (load_data),
    .load_keep (load_keep),
    .free      (out_free),
    .beat      (beat)
  );

`ifdef FIFO_RD_PACKER_STATS_EN
  // Counters advance on accepted beats; keep masks are contiguous from
  // slot 0, so a clear top bit marks a partial beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_beats   <= '0;
      stat_partial <= '0;
    end else if (beat.m_valid && beat.m_ready) begin
      stat_beats <= stat_beats + 32'd1;
      if (!beat.m_keep[PACK_RATIO-1]) begin
        stat_partial <= stat_partial + 16'd1;
      end
    end
  end
`endif

endmodule
